wb_regfile: RTL and testbench

- Consumer end of the MEM/WB pipeline interface: the write-back stage plus the 32-entry general register file.
- Takes the registered WB-stage controls, memory read data, ALU result and destination register from the MEM/WB register.
- Selects the write-back value and commits it to the register file.
- Serves the two ID-stage read ports, with same-cycle write-to-read bypass, so the decode stage sees the value being written back without an extra stall.

---
 rtl/wb_regfile.sv | 70 +++++++
 tb/tb_wb_regfile.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back stage and 32-entry general register file.
// Two combinational read ports with same-cycle bypass of the value being written back.
module wb_regfile #(
  parameter int unsigned rwidth = 5,
  parameter int unsigned word   = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              WB_RegWrite,
  input  logic              WB_MemtoReg,
  input  logic [word-1:0]   WB_Data_memory_Read_data,
  input  logic [word-1:0]   WB_ALU_result,
  input  logic [rwidth-1:0] WB_MUX8_out,
  input  logic [rwidth-1:0] ID_Read_register1,
  input  logic [rwidth-1:0] ID_Read_register2,
  output logic [word-1:0]   ID_Read_data1,
  output logic [word-1:0]   ID_Read_data2,
  output logic [word-1:0]   WB_Write_data,
  output logic              WB_Write_commit
);

  localparam int unsigned Entries = 2 ** rwidth;

  logic [word-1:0] regs_q [Entries];
  logic            commit_q;
  logic            write_en;
  logic            bypass_1;
  logic            bypass_2;

  always_comb begin
    WB_Write_data = WB_MemtoReg ? WB_Data_memory_Read_data : WB_ALU_result;
  end

  // Register 0 is never written, so it stays at its reset value of zero.
  assign write_en = WB_RegWrite & (WB_MUX8_out != '0);

  assign bypass_1 = WB_RegWrite & ~Reset & (WB_MUX8_out == ID_Read_register1) &
                    (ID_Read_register1 != '0);
  assign bypass_2 = WB_RegWrite & ~Reset & (WB_MUX8_out == ID_Read_register2) &
                    (ID_Read_register2 != '0);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      regs_q   <= '{default: '0};
      commit_q <= 1'b0;
    end else begin
      if (write_en) begin
        regs_q[WB_MUX8_out] <= WB_Write_data;
      end
      commit_q <= write_en;
    end
  end

  always_comb begin
    ID_Read_data1 = '0;
    if (ID_Read_register1 != '0) begin
      ID_Read_data1 = bypass_1 ? WB_Write_data : regs_q[ID_Read_register1];
    end
  end

  always_comb begin
    ID_Read_data2 = '0;
    if (ID_Read_register2 != '0) begin
      ID_Read_data2 = bypass_2 ? WB_Write_data : regs_q[ID_Read_register2];
    end
  end

  assign WB_Write_commit = commit_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_wb_regfile;

  logic        Clock;
  logic        Reset;
  logic        WB_RegWrite;
  logic        WB_MemtoReg;
  logic [31:0] WB_Data_memory_Read_data;
  logic [31:0] WB_ALU_result;
  logic [4:0]  WB_MUX8_out;
  logic [4:0]  ID_Read_register1;
  logic [4:0]  ID_Read_register2;
  logic [31:0] ID_Read_data1;
  logic [31:0] ID_Read_data2;
  logic [31:0] WB_Write_data;
  logic        WB_Write_commit;

  localparam int SelRd1    = 0;
  localparam int SelRd2    = 1;
  localparam int SelWdata  = 2;
  localparam int SelCommit = 3;

  typedef struct {
    int           cyc;
    int           sel;
    logic [31:0]  val;
    logic [127:0] nm;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_checks;
  int   n_fail;

  wb_regfile #(
    .rwidth (5),
    .word   (32)
  ) dut (
    .Clock                    (Clock),
    .Reset                    (Reset),
    .WB_RegWrite              (WB_RegWrite),
    .WB_MemtoReg              (WB_MemtoReg),
    .WB_Data_memory_Read_data (WB_Data_memory_Read_data),
    .WB_ALU_result            (WB_ALU_result),
    .WB_MUX8_out              (WB_MUX8_out),
    .ID_Read_register1        (ID_Read_register1),
    .ID_Read_register2        (ID_Read_register2),
    .ID_Read_data1            (ID_Read_data1),
    .ID_Read_data2            (ID_Read_data2),
    .WB_Write_data            (WB_Write_data),
    .WB_Write_commit          (WB_Write_commit)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // Monitor: every cycle the outputs are sampled mid-cycle and matched against the queue.
  always @(negedge Clock) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t        e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.sel)
        SelRd1:   act = ID_Read_data1;
        SelRd2:   act = ID_Read_data2;
        SelWdata: act = WB_Write_data;
        default:  act = {31'b0, WB_Write_commit};
      endcase
      n_checks++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %0s stale entry for cycle %0d seen at cycle %0d", e.nm, e.cyc, cyc);
      end else if (act !== e.val) begin
        n_fail++;
        $display("FAIL %0s cycle %0d actual=%h required=%h", e.nm, cyc, act, e.val);
      end
    end
  end

  task automatic expect_at(input int c, input int sel, input logic [31:0] val,
                           input logic [127:0] nm);
    exp_t e;
    e.cyc = c;
    e.sel = sel;
    e.val = val;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic we, input logic m2r,
                       input logic [31:0] mem, input logic [31:0] alu,
                       input logic [4:0] dst, input logic [4:0] r1, input logic [4:0] r2);
    Reset                    = rst;
    WB_RegWrite              = we;
    WB_MemtoReg              = m2r;
    WB_Data_memory_Read_data = mem;
    WB_ALU_result            = alu;
    WB_MUX8_out              = dst;
    ID_Read_register1        = r1;
    ID_Read_register2        = r2;
  endtask

  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    next_cycle();
    next_cycle();
    next_cycle();

    // All entries cleared; sweep both ports in opposite directions.
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(31 - i));
      expect_at(cyc, SelRd1, 32'h0, "rst_rd1");
      expect_at(cyc, SelRd2, 32'h0, "rst_rd2");
      if (i == 0) expect_at(cyc, SelCommit, 32'h0, "rst_commit");
      next_cycle();
    end

    // ALU write to reg 5, bypass then storage.
    drive(1'b0, 1'b1, 1'b0, 32'hCAFE0000, 32'h12345678, 5'd5, 5'd5, 5'd0);
    expect_at(cyc, SelRd1, 32'h12345678, "r5_bypass");
    expect_at(cyc, SelRd2, 32'h0, "r0_rd2");
    expect_at(cyc, SelWdata, 32'h12345678, "wdata_alu");
    expect_at(cyc, SelCommit, 32'h0, "commit_pre");
    expect_at(cyc + 1, SelCommit, 32'h1, "commit_r5");
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'hCAFE0000, 32'h12345678, 5'd5, 5'd5, 5'd0);
    expect_at(cyc, SelRd1, 32'h12345678, "r5_storage");
    expect_at(cyc + 1, SelCommit, 32'h0, "commit_drop");
    next_cycle();

    // Memory write to reg 9.
    drive(1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h00000001, 5'd9, 5'd9, 5'd9);
    expect_at(cyc, SelWdata, 32'hDEADBEEF, "wdata_mem");
    expect_at(cyc, SelRd1, 32'hDEADBEEF, "r9_byp1");
    expect_at(cyc, SelRd2, 32'hDEADBEEF, "r9_byp2");
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h00000001, 5'd9, 5'd9, 5'd5);
    expect_at(cyc, SelRd1, 32'hDEADBEEF, "r9_storage");
    expect_at(cyc, SelRd2, 32'h12345678, "r5_kept");
    expect_at(cyc, SelWdata, 32'h00000001, "wdata_sel0");
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd9, 5'd9, 5'd0);
    expect_at(cyc, SelRd1, 32'hDEADBEEF, "r9_no_we");
    expect_at(cyc, SelCommit, 32'h0, "commit_no_we");
    next_cycle();

    // Write to register 0 is dropped, including on the bypass path.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    expect_at(cyc, SelRd1, 32'h0, "r0_byp1");
    expect_at(cyc, SelRd2, 32'h0, "r0_byp2");
    expect_at(cyc, SelWdata, 32'hFFFFFFFF, "wdata_r0");
    expect_at(cyc + 1, SelCommit, 32'h0, "commit_r0");
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    expect_at(cyc, SelRd1, 32'h0, "r0_after1");
    expect_at(cyc, SelRd2, 32'h0, "r0_after2");
    next_cycle();

    // Back-to-back writes to reg 3.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000000A, 5'd3, 5'd3, 5'd3);
    expect_at(cyc, SelRd1, 32'h0000000A, "r3_a_rd1");
    expect_at(cyc, SelRd2, 32'h0000000A, "r3_a_rd2");
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000000B, 5'd3, 5'd3, 5'd3);
    expect_at(cyc, SelRd1, 32'h0000000B, "r3_b_rd1");
    expect_at(cyc, SelRd2, 32'h0000000B, "r3_b_rd2");
    expect_at(cyc, SelCommit, 32'h1, "commit_r3a");
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd3, 5'd3, 5'd4);
    expect_at(cyc, SelRd1, 32'h0000000B, "r3_last");
    expect_at(cyc, SelRd2, 32'h0, "r4_unwritten");
    expect_at(cyc, SelCommit, 32'h1, "commit_r3b");
    next_cycle();

    // Write during reset is lost; bypass suppressed.
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h00000055, 5'd7, 5'd7, 5'd7);
    expect_at(cyc, SelRd1, 32'h0, "r7_rst_rd1");
    expect_at(cyc, SelRd2, 32'h0, "r7_rst_rd2");
    expect_at(cyc, SelWdata, 32'h00000055, "wdata_rst");
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd7, 5'd7, 5'd5);
    expect_at(cyc, SelRd1, 32'h0, "r7_post_rst");
    expect_at(cyc, SelRd2, 32'h0, "r5_cleared");
    expect_at(cyc, SelCommit, 32'h0, "commit_rst");
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd3);
    expect_at(cyc, SelRd1, 32'h0, "r9_cleared");
    expect_at(cyc, SelRd2, 32'h0, "r3_cleared");
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h00000066, 5'd7, 5'd7, 5'd0);
    expect_at(cyc, SelRd1, 32'h00000066, "r7_byp");
    expect_at(cyc + 1, SelCommit, 32'h1, "commit_r7");
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd7, 5'd0, 5'd7);
    expect_at(cyc, SelRd2, 32'h00000066, "r7_storage");
    next_cycle();

    next_cycle();
    next_cycle();
    if (sb.size() != 0) begin
      n_fail += sb.size();
      $display("FAIL scoreboard_drain %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
